// File: rtl/aes_round_engine_pkg.sv
// Shared types, key-size codes and GF(2^8) helpers
// for the iterative AES round engine.
package aes_round_engine_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_FINAL,
    S_DONE
  } fsm_t;

  localparam logic [3:0] NK_128 = 4'd3;
  localparam logic [3:0] NK_192 = 4'd5;
  localparam logic [3:0] NK_256 = 4'd7;
  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  // Zero marks an unsupported key size.
  function automatic logic [3:0] nr_of(input logic [3:0] nk);
    logic [3:0] nr;
    nr = 4'd0;
    unique case (1'b1)
      (nk == NK_128): nr = NR_128;
      (nk == NK_192): nr = NR_192;
      (nk == NK_256): nr = NR_256;
      default: nr = 4'd0;
    endcase
    return nr;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      r[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES S-box: GF(2^8) inverse (a^254) followed by
// the affine transform.
module aes_sbox
  import aes_round_engine_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  function automatic logic [7:0] gf_mul(
    input logic [7:0] x,
    input logic [7:0] z
  );
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0.
  always_comb begin
    sq  = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    y = inv
      ^ {inv[6:0], inv[7]}
      ^ {inv[5:0], inv[7:6]}
      ^ {inv[4:0], inv[7:5]}
      ^ {inv[3:0], inv[7:4]}
      ^ 8'h63;
  end

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES encryption engine: one round per cycle,
// round keys fetched from an external expansion memory.
module aes_round_engine
  import aes_round_engine_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] din,
  input  logic [3:0]   nk,
  output logic [3:0]   key_addr,
  input  logic [128:0] key_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] dout,
  output logic         err
);

  fsm_t         fsm;
  logic [127:0] st;
  logic [3:0]   rnd;
  logic [3:0]   nk_q;
  logic [3:0]   nr;
  logic [127:0] sb;
  logic [127:0] sr;
  logic [127:0] mc;
  logic [127:0] rk;
  logic         kv;

  assign rk = key_in[127:0];
  assign kv = key_in[128];
  assign nr = nr_of(nk_q);

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .a (st[127-8*i -: 8]),
      .y (sb[127-8*i -: 8])
    );
  end

  // Byte (r,c) sits at index r+4c; row r rotates left by r.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[127-8*(r+4*c) -: 8] =
        sb[127-8*(r+4*((c+r)%4)) -: 8];
    end
  end

  assign mc = mix_columns(sr);

  always_comb begin
    key_addr = '0;
    unique case (1'b1)
      (fsm == S_ROUND): key_addr = rnd;
      (fsm == S_FINAL): key_addr = nr;
      default:          key_addr = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm  <= S_IDLE;
      st   <= '0;
      rnd  <= '0;
      nk_q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      dout <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (fsm)
        S_IDLE: begin
          if (start) begin
            if (nr_of(nk) == 4'd0) begin
              err <= 1'b1;
            end else if (kv) begin
              st   <= din ^ rk;
              rnd  <= 4'd1;
              nk_q <= nk;
              busy <= 1'b1;
              fsm  <= S_ROUND;
            end
          end
        end
        S_ROUND: begin
          if (kv) begin
            st  <= mc ^ rk;
            rnd <= rnd + 4'd1;
            if (rnd == nr - 4'd1) fsm <= S_FINAL;
          end
        end
        S_FINAL: begin
          if (kv) begin
            st  <= sr ^ rk;
            fsm <= S_DONE;
          end
        end
        S_DONE: begin
          dout <= st;
          done <= 1'b1;
          busy <= 1'b0;
          fsm  <= S_IDLE;
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_engine.sv
// Bench for aes_round_engine: FIPS-197 vectors plus random
// blocks against a byte-level AES model with its own key schedule.
module tb_aes_round_engine;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] din = '0;
  logic [3:0]   nk = '0;
  logic [3:0]   key_addr;
  logic [128:0] key_in;
  logic         busy;
  logic         done;
  logic [127:0] dout;
  logic         err;

  logic         kvalid = 1'b1;
  logic [127:0] rk_mem [0:15];
  logic [7:0]   sbox [0:255];
  int           n_tests = 0;
  int           n_fail = 0;

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  always #5 clk = ~clk;

  always_comb key_in = {kvalid, rk_mem[key_addr]};

  aes_round_engine dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .din      (din),
    .nk       (nk),
    .key_addr (key_addr),
    .key_in   (key_in),
    .busy     (busy),
    .done     (done),
    .dout     (dout),
    .err      (err)
  );

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Walk the multiplicative group with generator 3 and its inverse.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
      sbox[p] = x;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic expand_key(input int nkc, input logic [255:0] key);
    int nkw;
    int nr;
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0] rcon;
    nkw = nkc + 1;
    nr = nkw + 6;
    rcon = 8'h01;
    for (int i = 0; i < nkw; i++) w[i] = key[255-32*i -: 32];
    for (int i = nkw; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nkw == 0) begin
        t = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nkw > 6 && i % nkw == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nkw] ^ t;
    end
    for (int r = 0; r <= nr; r++)
      rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] model(input logic [127:0] pt,
                                         input int nkc);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] res;
    int nr;
    nr = nkc + 7;
    for (int i = 0; i < 16; i++)
      s[i] = pt[127-8*i -: 8] ^ rk_mem[0][127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) s[w+4*c] = t[w+4*((c+w)%4)];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
          s[4*c+3] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk_mem[r][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // lat counts edges from the accepting edge (edge 1) to the edge raising done.
  task automatic run(input logic [127:0] pt, input int nkc,
                     input int pre_wait, input int stall_at,
                     input int stall_len, input bit poke,
                     output logic [127:0] res, output int lat);
    int edges;
    int left;
    bit stalled;
    edges = 0;
    left = 0;
    stalled = 0;
    @(negedge clk);
    din = pt;
    nk = nkc[3:0];
    start = 1'b1;
    if (pre_wait > 0) begin
      kvalid = 1'b0;
      repeat (pre_wait) begin
        @(posedge clk); #1;
        chk("wait_busy", 128'(busy), 128'd0);
      end
      kvalid = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    chk("accept_busy", 128'(busy), 128'd1);
    while (!done && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (poke && edges == 4) begin
        start = 1'b1; nk = 4'd5; din = ~pt;
      end
      if (poke && edges == 6) begin
        start = 1'b0; nk = nkc[3:0]; din = pt;
      end
      if (stalled && left > 0) begin
        left--;
        if (left == 0) kvalid = 1'b1;
      end else if (!stalled && stall_len > 0 && key_addr == stall_at[3:0]) begin
        kvalid = 1'b0;
        stalled = 1;
        left = stall_len;
      end
    end
    kvalid = 1'b1;
    lat = edges;
    res = dout;
    @(posedge clk); #1;
    chk("done_pulse", 128'(done), 128'd0);
    chk("busy_clear", 128'(busy), 128'd0);
  endtask

  initial begin
    logic [127:0] res;
    logic [127:0] pt;
    logic [255:0] key;
    int lat;
    int nkc;
    int sat;
    int slen;
    int cnt;

    for (int i = 0; i < 16; i++) rk_mem[i] = '0;
    build_sbox();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout, 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    chk("rst_kaddr", 128'(key_addr), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    expand_key(3, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
    run(PT, 3, 0, 0, 0, 0, res, lat);
    chk("aes128", res, C128);
    chk("lat128", 128'(lat), 128'd12);

    expand_key(5, {192'h000102030405060708090a0b0c0d0e0f1011121314151617,
                   64'h0});
    run(PT, 5, 0, 0, 0, 0, res, lat);
    chk("aes192", res, C192);
    chk("lat192", 128'(lat), 128'd14);

    expand_key(7, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    run(PT, 7, 0, 0, 0, 0, res, lat);
    chk("aes256", res, C256);
    chk("lat256", 128'(lat), 128'd16);

    expand_key(3, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
    run(PT, 3, 0, 5, 3, 0, res, lat);
    chk("stall_res", res, C128);
    chk("stall_lat", 128'(lat), 128'd15);

    run(PT, 3, 2, 0, 0, 1, res, lat);
    chk("poke_res", res, C128);
    chk("poke_lat", 128'(lat), 128'd12);

    @(negedge clk);
    nk = 4'd4;
    din = ~PT;
    start = 1'b1;
    @(posedge clk); #1;
    chk("err_pulse", 128'(err), 128'd1);
    chk("err_busy", 128'(busy), 128'd0);
    chk("err_dout", dout, C128);
    start = 1'b0;
    @(posedge clk); #1;
    chk("err_clear", 128'(err), 128'd0);
    chk("err_idle", 128'(busy), 128'd0);

    @(negedge clk);
    din = ~PT;
    nk = 4'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    while (key_addr != 4'd7 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("reach_rnd7", 128'(key_addr), 128'd7);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_dout", dout, 128'd0);
    chk("arst_busy", 128'(busy), 128'd0);
    chk("arst_kaddr", 128'(key_addr), 128'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("arst_done", 128'(done), 128'd0);
      chk("arst_err", 128'(err), 128'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_done", 128'(done), 128'd0);
    run(PT, 3, 0, 0, 0, 0, res, lat);
    chk("post_rst_res", res, C128);
    chk("post_rst_lat", 128'(lat), 128'd12);

    for (int k = 0; k < 8; k++) begin
      nkc = 3 + 2 * int'($urandom_range(0, 2));
      for (int j = 0; j < 8; j++) key[255-32*j -: 32] = $urandom;
      for (int j = 0; j < 4; j++) pt[127-32*j -: 32] = $urandom;
      expand_key(nkc, key);
      slen = (k % 2 == 1) ? int'($urandom_range(1, 3)) : 0;
      sat = int'($urandom_range(1, nkc + 6));
      run(pt, nkc, 0, sat, slen, 0, res, lat);
      chk("rand_res", res, model(pt, nkc));
      chk("rand_lat", 128'(lat), 128'(nkc + 9 + slen));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_round_engine.md
AES_ROUND_ENGINE -- requirements
Module: aes_round_engine

Interface
REQ-001 SHALL have parameter NONE (round count is derived from nk at run time; no compile-time parameters).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to encrypt din, sampled only in IDLE.
REQ-005 din  input  128  plaintext block, bit 127 = byte 0 (FIPS-197 column-major order).
REQ-006 nk  input  4  key size code: 3 = AES-128, 5 = AES-192, 7 = AES-256, sampled with start.
REQ-007 key_addr  output  4  round-key index presented to the key-expansion memory.
REQ-008 key_in  input  129  round key at key_addr, combinational read; bit 128 = valid, bits 127:0 = key (w0 at MSB).
REQ-009 busy  output  1  high from accepted start until done.
REQ-010 done  output  1  one-cycle pulse when dout is updated.
REQ-011 dout  output  128  ciphertext, held until the next accepted start.
REQ-012 err  output  1  one-cycle pulse on start with unsupported nk.

Function
REQ-013 SHALL map nk to Nr: 3 maps to 10, 5 maps to 12, and 7 maps to 14; the nk value and Nr are latched at start acceptance.
REQ-014 SHALL implement the FSM states IDLE, ROUND, FINAL, and DONE.
REQ-015 IDLE: key_addr = 0; on start with a valid nk and key_in[128] = 1, the FSM SHALL load state = din ^ key_in[127:0], set rnd = 1, set busy, and go to ROUND.
REQ-016 IDLE with start and an invalid nk: the block SHALL pulse err and stay in IDLE without changing dout.
REQ-017 IDLE with start, a valid nk, and key_in[128] = 0: the block SHALL NOT accept the start, and SHALL accept on the first cycle that key_in[128] is high while start is still high.
REQ-018 ROUND: key_addr = rnd; the state SHALL update to MixColumns(ShiftRows(SubBytes(state))) ^ key_in[127:0], and rnd SHALL increment; when rnd = Nr-1, the next state SHALL be FINAL.
REQ-019 FINAL: key_addr = Nr; the state SHALL update to ShiftRows(SubBytes(state)) ^ key_in[127:0], and the FSM SHALL go to DONE.
REQ-020 DONE: the block SHALL register state into dout, pulse done for 1 cycle, clear busy, and return to IDLE.
REQ-021 Stall: in ROUND or FINAL, if key_in[128] = 0, the block SHALL hold state, rnd, and the FSM state unchanged until the valid bit is high.
REQ-022 Latency without stall: done SHALL assert Nr+2 rising edges after the accepting edge; this is 12 edges for AES-128, 14 for AES-192, and 16 for AES-256.
REQ-023 start while busy SHALL be ignored, with no queueing.
REQ-024 rnd SHALL be 4 bits wide and SHALL never exceed 14; the block SHALL NOT issue key_addr values above Nr.
REQ-025 MixColumns SHALL use xtime(b) = {b[6:0],0} ^ (8'h1b & {8{b[7]}}).

Reset
REQ-026 On rst_n low, the block SHALL immediately enter IDLE and clear state, rnd, and dout to 0; busy, done, and err SHALL be 0, and key_addr SHALL be 0.
REQ-027 Reset mid-operation SHALL abort the encryption with no done pulse; the next start after release SHALL run normally.

Structure
REQ-028 A shared package SHALL hold the FSM state encodings, the nk codes (3/5/7), the Nr constants (10/12/14), and the xtime/MixColumns helper functions.
REQ-029 The block SHALL instantiate 16 copies of the existing sub-module aes_sbox for SubBytes; no other sub-modules are permitted.
REQ-030 ShiftRows and AddRoundKey SHALL be pure wiring and XOR within this module; there SHALL be one round datapath, iterated once per cycle.

Verification
REQ-031 AES-128: with din 00112233445566778899aabbccddeeff and key 000102...0f expanded, start leads to dout 69c4e0d86a7b0430d8cdb78070b4c55a with done 12 edges after acceptance.
REQ-032 AES-192: with the same din and key 000102...17, dout SHALL be dda97ca4864cdfe06eaf70a0ec0d7191 with done after 14 edges; AES-256 with key 000102...1f SHALL give 8ea2b7ca516745bfeafc49904b496089 after 16 edges.
REQ-033 Stall: in the AES-128 run, drop key_in[128] for 3 cycles at rnd = 5; the result SHALL be unchanged and done SHALL be delayed by exactly 3 cycles.
REQ-034 Invalid nk = 4 with start SHALL produce an err pulse with busy = 0 and dout unchanged; start while busy SHALL NOT change dout or the timing of the run in progress.
REQ-035 Asserting rst_n low at rnd = 7 SHALL produce no done, SHALL leave all outputs at 0 during reset, and a subsequent AES-128 start SHALL produce 69c4e0d8...c55a.
